ifu_fetch: RTL

Instruction fetch stage sitting directly downstream of the `PC` block. It consumes the current program counter, issues word reads to instruction memory over a valid/ready request channel, and matches in-order responses to their issuing PCs. It buffers fetched instructions in a small in-order queue and presents them to decode with a valid/ready handshake. A redirect from the same `jmp` that steers `PC` flushes everything in flight.

---
 rtl/ifu_fetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage between the PC block and decode.
// Issues word reads for the current PC, tags each accepted request with a
// queue slot, fills slots from in-order responses and hands filled slots to
// decode in program order. A flush drops every queued slot and counts the
// responses still owed by memory so they can be swallowed on arrival.
module ifu_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_val,
  output logic        pc_hold,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] discard_q, discard_d;

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [PW-1:0] used;
  logic [PW-1:0] unfilled;
  logic [PW:0]   occupancy;
  logic [IW-1:0] alloc_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] head_idx;
  logic          accept;
  logic          pop;
  logic          rsp_fill;
  logic          rsp_drop;

  assign alloc_idx = alloc_ptr_q[IW-1:0];
  assign fill_idx  = fill_ptr_q[IW-1:0];
  assign head_idx  = head_ptr_q[IW-1:0];

  // Slots held by live requests, slots still waiting for data, and total
  // memory-side occupancy including responses owed to flushed requests.
  assign used      = alloc_ptr_q - head_ptr_q;
  assign unfilled  = alloc_ptr_q - fill_ptr_q;
  assign occupancy = {1'b0, used} + {1'b0, discard_q};

  assign imem_req_valid = rst & ~flush & (occupancy < DEPTH_W);
  assign imem_req_addr  = {pc_val[31:2], 2'b00};
  assign accept         = imem_req_valid & imem_req_ready;
  assign pc_hold        = ~accept;

  assign inst_valid = (used != '0) & filled_q[head_idx];
  assign inst_data  = data_q[head_idx];
  assign inst_pc    = pc_q[head_idx];

  assign pop      = inst_valid & inst_ready & ~flush;
  assign rsp_drop = imem_rsp_valid & (discard_q != '0);
  assign rsp_fill = imem_rsp_valid & (discard_q == '0);

  // Next-state for queue contents, pointers and the stale-response counter.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    discard_d   = discard_q;
    pc_d        = pc_q;
    data_d      = data_q;
    filled_d    = filled_q;

    if (flush) begin
      filled_d    = '0;
      alloc_ptr_d = head_ptr_q;
      fill_ptr_d  = head_ptr_q;
      discard_d   = discard_q + unfilled - {{(PW-1){1'b0}}, imem_rsp_valid};
    end else begin
      if (pop) begin
        filled_d[head_idx] = 1'b0;
        head_ptr_d         = head_ptr_q + 1'b1;
      end
      if (accept) begin
        pc_d[alloc_idx]     = pc_val;
        filled_d[alloc_idx] = 1'b0;
        alloc_ptr_d         = alloc_ptr_q + 1'b1;
      end
      if (rsp_fill) begin
        data_d[fill_idx]   = imem_rsp_data;
        filled_d[fill_idx] = 1'b1;
        fill_ptr_d         = fill_ptr_q + 1'b1;
      end
      if (rsp_drop) begin
        discard_d = discard_q - 1'b1;
      end
    end
  end

  // State registers; reset clears every slot so decode sees zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      discard_q   <= '0;
      filled_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      discard_q   <= discard_d;
      filled_q    <= filled_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
    end
  end

endmodule
